// File: rtl/heapsort_pkg.sv
// Shared widths and read-side FSM states for the heapsort core.
package heapsort_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 10;

   typedef enum logic [1:0] {IDLE, FETCH, LATCH, WAIT_FS} state_t;
endpackage

// File: rtl/sorted_stream_out_fs_edge_det.sv
// Rising-edge detector for the sample-rate strobe.
module fs_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic fs,
   output logic fs_rise
);
   logic r_fs_d;

   // Resetting to 1 keeps a strobe already high at reset release from counting as an edge.
   always_ff @(posedge clk) begin
      if (rst) r_fs_d <= 1'b1;
      else     r_fs_d <= fs;
   end

   assign fs_rise = fs & ~r_fs_d;
endmodule

// File: rtl/sorted_stream_out.sv
// Streams one sorted frame out of a RAM bank, one word per fs rising edge,
// with a one-word prefetch buffer hiding the RAM read latency.
module sorted_stream_out
   import heapsort_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter bit ORDER  = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fs,
   input  logic              sort_done,
   input  logic              sort_bank,
   output logic              ram_rd_en,
   output logic [ADDR_W:0]   ram_addr,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              frame_start,
   output logic              busy,
   output logic              overrun,
   output logic              underrun
);
   state_t              r_state;
   logic                r_bank;
   logic [ADDR_W-1:0]   r_idx;
   logic [ADDR_W-1:0]   r_count;
   logic [DATA_W-1:0]   r_buf;
   logic [DATA_W-1:0]   r_dout;
   logic                r_valid;
   logic                r_fstart;
   logic                r_busy;
   logic                r_overrun;
   logic                r_underrun;

   logic                w_fs_rise;
   logic                w_last;
   logic [ADDR_W-1:0]   w_idx_nxt;

   fs_edge_det u_fs_edge (
      .clk     (clk),
      .rst     (rst),
      .fs      (fs),
      .fs_rise (w_fs_rise)
   );

   assign w_last    = &r_count;
   assign w_idx_nxt = ORDER ? (r_idx - ADDR_W'(1)) : (r_idx + ADDR_W'(1));

   // The next read is issued on the fs edge itself so the buffer refills
   // in LATCH and the FSM is back in WAIT_FS two clocks after the edge.
   assign ram_rd_en = (r_state == FETCH) |
                      ((r_state == WAIT_FS) & w_fs_rise & ~w_last);
   assign ram_addr  = {r_bank, (r_state == WAIT_FS) ? w_idx_nxt : r_idx};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_bank     <= 1'b0;
         r_idx      <= '0;
         r_count    <= '0;
         r_buf      <= '0;
         r_dout     <= '0;
         r_valid    <= 1'b0;
         r_fstart   <= 1'b0;
         r_busy     <= 1'b0;
         r_overrun  <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_valid  <= 1'b0;
         r_fstart <= 1'b0;
         if (sort_done && r_busy) r_overrun <= 1'b1;
         if (w_fs_rise && (r_state == FETCH || r_state == LATCH)) r_underrun <= 1'b1;
         case (r_state)
            IDLE: begin
               if (sort_done) begin
                  r_bank  <= sort_bank;
                  r_idx   <= ORDER ? '1 : '0;
                  r_count <= '0;
                  r_busy  <= 1'b1;
                  r_state <= FETCH;
               end
            end
            FETCH: r_state <= LATCH;
            LATCH: begin
               r_buf   <= ram_rdata;
               r_state <= WAIT_FS;
            end
            WAIT_FS: begin
               if (w_fs_rise) begin
                  r_dout   <= r_buf;
                  r_valid  <= 1'b1;
                  r_fstart <= (r_count == '0);
                  r_count  <= r_count + ADDR_W'(1);
                  if (w_last) begin
                     r_busy  <= 1'b0;
                     r_state <= IDLE;
                  end else begin
                     r_idx   <= w_idx_nxt;
                     r_state <= LATCH;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign data_out    = r_dout;
   assign data_valid  = r_valid;
   assign frame_start = r_fstart;
   assign busy        = r_busy;
   assign overrun     = r_overrun;
   assign underrun    = r_underrun;
endmodule

// File: tb/tb_sorted_stream_out.sv
// Directed bench: ascending (bank 0) and descending (bank 1) instances both
// must stream 0..1023; a per-instance queue holds the expected words.
module tb_sorted_stream_out;
   typedef struct packed {
      logic [15:0] d;
      logic        first;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        fs;
   logic        sort_done;
   bit          fs_run;

   logic        ram_rd_en   [2];
   logic [10:0] ram_addr    [2];
   logic [15:0] ram_rdata   [2];
   logic [15:0] dout        [2];
   logic        dv          [2];
   logic        fst         [2];
   logic        bsy         [2];
   logic        ovr         [2];
   logic        unr         [2];

   exp_t        exp_q [2][$];
   int          n_seen [2];
   int          n_cmp = 0;
   int          n_err = 0;
   exp_t        e;

   always #10 clk = ~clk;

   sorted_stream_out #(.DATA_W(16), .ADDR_W(10), .ORDER(1'b0)) dut0 (
      .clk(clk), .rst(rst), .fs(fs), .sort_done(sort_done), .sort_bank(1'b0),
      .ram_rd_en(ram_rd_en[0]), .ram_addr(ram_addr[0]), .ram_rdata(ram_rdata[0]),
      .data_out(dout[0]), .data_valid(dv[0]), .frame_start(fst[0]),
      .busy(bsy[0]), .overrun(ovr[0]), .underrun(unr[0]));

   sorted_stream_out #(.DATA_W(16), .ADDR_W(10), .ORDER(1'b1)) dut1 (
      .clk(clk), .rst(rst), .fs(fs), .sort_done(sort_done), .sort_bank(1'b1),
      .ram_rd_en(ram_rd_en[1]), .ram_addr(ram_addr[1]), .ram_rdata(ram_rdata[1]),
      .data_out(dout[1]), .data_valid(dv[1]), .frame_start(fst[1]),
      .busy(bsy[1]), .overrun(ovr[1]), .underrun(unr[1]));

   // RAM model: bank 0 holds i at index i, bank 1 holds 1023-i.
   function automatic logic [15:0] mem(input logic [10:0] a);
      return a[10] ? 16'(10'd1023 - a[9:0]) : 16'(a[9:0]);
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++)
         if (ram_rd_en[k]) ram_rdata[k] <= mem(ram_addr[k]);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (dv[k] === 1'b1) begin
            if (exp_q[k].size() == 0) begin
               check($sformatf("spurious_valid%0d", k), 32'(dv[k]), 32'd0);
            end else begin
               e = exp_q[k].pop_front();
               check($sformatf("data%0d", k), 32'(dout[k]), 32'(e.d));
               check($sformatf("frame_start%0d", k), 32'(fst[k]), 32'(e.first));
               check($sformatf("busy_at_valid%0d", k), 32'(bsy[k]), 32'(!e.last));
               n_seen[k]++;
            end
         end else begin
            check($sformatf("frame_start_idle%0d", k), 32'(fst[k]), 32'd0);
         end
      end
   end

   task automatic step();
      @(negedge clk);
      if (fs_run) fs = ~fs;
   endtask

   task automatic push_frame();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 1024; i++)
            exp_q[k].push_back('{d: 16'(i), first: (i == 0), last: (i == 1023)});
   endtask

   task automatic wait_busy_fall();
      int guard;
      guard = 0;
      while (bsy[0] !== 1'b0 && guard < 3000) begin
         step();
         guard++;
      end
      if (guard >= 3000) check("busy_fall_timeout", 32'(bsy[0]), 32'd0);
      step();
   endtask

   // Pulse sort_done with fs held low, then start fs once in WAIT_FS.
   task automatic clean_frame(input bit check_addr);
      fs_run = 0;
      fs = 1'b0;
      step();
      sort_done = 1'b1;
      push_frame();
      step();
      sort_done = 1'b0;
      if (check_addr) begin
         check("rd_en_first0", 32'(ram_rd_en[0]), 32'd1);
         check("addr_first0", 32'(ram_addr[0]), 32'h000);
         check("rd_en_first1", 32'(ram_rd_en[1]), 32'd1);
         check("addr_first1", 32'(ram_addr[1]), 32'h7FF);
         check("busy_start0", 32'(bsy[0]), 32'd1);
      end
      step();
      step();
      fs_run = 1;
   endtask

   initial begin
      int base, guard;
      rst = 1'b1;
      fs = 1'b1;
      sort_done = 1'b0;
      fs_run = 0;
      n_seen[0] = 0;
      n_seen[1] = 0;
      repeat (3) step();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst_dout%0d", k), 32'(dout[k]), 32'd0);
         check($sformatf("rst_valid%0d", k), 32'(dv[k]), 32'd0);
         check($sformatf("rst_busy%0d", k), 32'(bsy[k]), 32'd0);
         check($sformatf("rst_ovr%0d", k), 32'(ovr[k]), 32'd0);
         check($sformatf("rst_unr%0d", k), 32'(unr[k]), 32'd0);
         check($sformatf("rst_rd_en%0d", k), 32'(ram_rd_en[k]), 32'd0);
      end

      // fs held high across reset release: no edge, no flags
      rst = 1'b0;
      repeat (4) step();
      check("fs_high_release_valid", 32'(dv[0]), 32'd0);
      check("fs_high_release_unr", 32'(unr[0]), 32'd0);

      // Frame 1: clean run
      clean_frame(1'b1);
      wait_busy_fall();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("f1_words%0d", k), 32'(n_seen[k]), 32'd1024);
         check($sformatf("f1_ovr%0d", k), 32'(ovr[k]), 32'd0);
         check($sformatf("f1_unr%0d", k), 32'(unr[k]), 32'd0);
         check($sformatf("f1_hold%0d", k), 32'(dout[k]), 32'd1023);
      end

      // Frame 2: extra sort_done mid-frame
      clean_frame(1'b0);
      base = n_seen[0];
      guard = 0;
      while (n_seen[0] < base + 100 && guard < 1000) begin step(); guard++; end
      sort_done = 1'b1;
      step();
      sort_done = 1'b0;
      wait_busy_fall();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("f2_words%0d", k), 32'(n_seen[k]), 32'd2048);
         check($sformatf("f2_ovr%0d", k), 32'(ovr[k]), 32'd1);
         check($sformatf("f2_unr%0d", k), 32'(unr[k]), 32'd0);
      end

      // Frame 3: fs rises 1 clk after sort_done, then reset after word 500
      fs_run = 0;
      fs = 1'b0;
      step();
      sort_done = 1'b1;
      push_frame();
      step();
      sort_done = 1'b0;
      fs = 1'b1;
      step();
      fs = 1'b0;
      fs_run = 1;
      check("f3_unr0", 32'(unr[0]), 32'd1);
      check("f3_unr1", 32'(unr[1]), 32'd1);
      base = n_seen[0];
      guard = 0;
      while (n_seen[0] < base + 501 && guard < 2000) begin step(); guard++; end
      if (guard >= 2000) check("word500_timeout", 32'(n_seen[0]), 32'(base + 501));
      rst = 1'b1;
      step();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("mid_rst_valid%0d", k), 32'(dv[k]), 32'd0);
         check($sformatf("mid_rst_dout%0d", k), 32'(dout[k]), 32'd0);
         check($sformatf("mid_rst_busy%0d", k), 32'(bsy[k]), 32'd0);
         check($sformatf("mid_rst_unr%0d", k), 32'(unr[k]), 32'd0);
         check($sformatf("mid_rst_ovr%0d", k), 32'(ovr[k]), 32'd0);
         exp_q[k].delete();
      end
      step();
      rst = 1'b0;
      repeat (4) step();
      check("post_rst_valid0", 32'(dv[0]), 32'd0);

      // Frame 4: restart from word 0 after mid-frame reset
      base = n_seen[0];
      clean_frame(1'b1);
      wait_busy_fall();
      check("f4_words0", 32'(n_seen[0] - base), 32'd1024);
      check("f4_qempty0", 32'(exp_q[0].size()), 32'd0);
      check("f4_qempty1", 32'(exp_q[1].size()), 32'd0);
      check("f4_unr0", 32'(unr[0]), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/sorted_stream_out.md
Name: sorted_stream_out

Overview:
Read-side companion of the heapsort core. After the sorter finishes a frame in one bank of the dual-port RAM, this block reads that bank and streams one sorted sample per rising edge of the sample-rate strobe fs. It is the output counterpart of the fs-paced sample intake: words enter the sorter at fs rate and leave here at fs rate. One-word prefetch keeps RAM latency hidden.

Parameters:
DATA_W, 16, sample width
ADDR_W, 10, log2 of frame length N (N = 1024)
ORDER, 0, 0 = ascending (address 0 up to N-1), 1 = descending (N-1 down to 0)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
fs  in  1  sample-rate strobe, level, synchronous to clk; active edge is rising
sort_done  in  1  one-clk pulse: bank sort_bank holds a fully sorted frame
sort_bank  in  1  bank of the completed sort, valid with sort_done
ram_rd_en  out  1  RAM read-port enable
ram_addr  out  ADDR_W+1  read address, {bank, index}
ram_rdata  in  DATA_W  read data, valid exactly 1 clk after ram_rd_en
data_out  out  DATA_W  sorted sample; holds last value between valids
data_valid  out  1  one-clk pulse per emitted sample
frame_start  out  1  pulse coincident with data_valid of the frame's first word
busy  out  1  high from accepted sort_done until the last word is emitted
overrun  out  1  sticky: sort_done arrived while busy
underrun  out  1  sticky: fs rising edge arrived while prefetch buffer was empty

Behaviour:
- Reset: all outputs 0. FSM in IDLE. fs_d resets to 1, so fs held high at reset release is not a rising edge. overrun and underrun are cleared only by rst.
- fs_rise = fs & ~fs_d, where fs_d is fs registered on clk. Minimum supported spacing between rises is 2 clk.
- IDLE: on sort_done, latch bank, set idx = 0 (ORDER 0) or N-1 (ORDER 1), count = 0, busy <= 1, go FETCH.
- FETCH (one cycle): ram_rd_en = 1, ram_addr = {bank, idx}; go LATCH.
- LATCH (one cycle): buf <= ram_rdata; go WAIT_FS.
- WAIT_FS on fs_rise: on the next cycle data_out <= buf and data_valid = 1; frame_start = 1 if count == 0. Then count++.
  - If the emitted word was the last one (count was N-1), busy <= 0 in the same cycle as data_valid, and go IDLE.
  - Otherwise, in the same cycle, step idx by +1 or -1 and issue the read (ram_rd_en = 1 on the step cycle), then go LATCH. The block is back in WAIT_FS 2 clk after fs_rise.
- fs_rise in FETCH or LATCH: underrun <= 1; no word is emitted; the pending word goes out on the next fs_rise.
- fs_rise in IDLE: ignored.
- sort_done while busy: ignored, overrun <= 1.
- sort_done in the same cycle as the final emission: ignored, because busy is still 1.
- Latency: sort_done at cycle t gives ram_rd_en at t+1 and buf loaded at t+2. The first data_valid comes 1 clk after the first fs_rise sampled at cycle >= t+3.
- idx never wraps: count terminates the frame at exactly N words.
- rst mid-frame: immediate return to IDLE; no further valids; data_out = 0.

Decomposition:
- Shared package heapsort_pkg: DATA_W, ADDR_W defaults; the FSM state enum (IDLE, FETCH, LATCH, WAIT_FS).
- One sub-module, fs_edge_det: registers fs and outputs the one-clk fs_rise pulse; fs_d reset value 1.

Test Plan:
- Clock 20 ns, fs period 40 ns, RAM model bank0 = 0..1023, sort_done with bank 0 → exactly 1024 data_valid pulses, data_out 0,1,...,1023; frame_start only with value 0; busy falls with the valid carrying 1023; overrun = 0, underrun = 0.
- ORDER=1, bank 1 preloaded with 1023-i at index i → output 0,1,...,1023, first read address {1, 1023}.
- Second sort_done pulsed mid-frame → overrun = 1, current frame completes unchanged. A sort_done after busy falls starts a new frame.
- fs forced high through reset release → no spurious valid. sort_done issued 1 clk before an fs rise → underrun = 1, word 0 emitted on the following rise.
- rst asserted after word 500 → data_valid = 0 and data_out = 0 from the next cycle. A new sort_done restarts from word 0 with frame_start.
